// File: rtl/uart_obi_pkg.sv
// Shared constants and state types for the OBI UART peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_obi_pkg;

    // Word index of each register (byte offset bits [3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_BUSY    = 5;
    localparam int ST_FRAME_ERR  = 6;

    // IRQ_EN bit positions
    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // RX_BREAK holds off after a framing error until the line returns high
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_obi_periph_if.sv
// OBI data-port slice seen by the UART: request, grant and response.
// Latency: n/a (wiring only).
// Backpressure: gnt stalls the master; rvalid has no ready.
interface uart_obi_periph_if;
    logic        req;
    logic        gnt;
    logic [3:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Count-based synchronous FIFO with show-ahead read data.
// Latency: push visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy update; push+pop on full leaves the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/uart_obi_periph.sv
// OBI memory-mapped UART: TX/RX FIFOs, programmable divider, sticky errors, level IRQ.
// Latency: response one cycle after grant; TX line starts one cycle after the push edge.
// Backpressure: gnt withheld for DATA writes while the TX FIFO is full.
module uart_obi_periph
    import uart_obi_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUDRATE  = 115200,
    parameter int DIV_WIDTH = 16,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_obi_periph_if.slave  bus,
    output logic              ser_tx_o,
    input  logic              ser_rx_i,
    output logic              irq_o
);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(CLK_FREQ / BAUDRATE);

    // ---------------- bus decode ----------------
    logic [1:0]           word;
    logic                 wr_data_hit;
    logic                 acc;
    logic                 reg_wr;
    logic [31:0]          be_mask;
    logic [31:0]          rd_mux;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 unused_bus_bits;

    // ---------------- control registers ----------------
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [1:0]           irq_en_q;
    logic                 rx_overrun_q;
    logic                 frame_err_q;

    // ---------------- FIFOs ----------------
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]           tx_dout;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]           rx_dout;

    // ---------------- TX engine ----------------
    tx_state_e            tx_state;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [DIV_WIDTH-1:0] tx_per;
    logic [2:0]           tx_bit;
    logic [7:0]           tx_sh;
    logic                 ser_tx_q;
    logic                 tx_bound;
    logic                 tx_busy;

    // ---------------- RX engine ----------------
    rx_state_e            rx_state;
    logic [1:0]           rx_sync;
    logic                 rx_s;
    logic                 rx_prev;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [DIV_WIDTH-1:0] rx_per;
    logic [2:0]           rx_bit;
    logic [7:0]           rx_sh;
    logic                 rx_bound;
    logic                 rx_mid;
    logic                 rx_fall;
    logic                 rx_frame_evt;
    logic                 rx_ovf_evt;

    assign word            = bus.addr[3:2];
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:8], bus.be[3:1]};
    assign wr_data_hit     = bus.req & bus.we & (word == REG_DATA) & bus.be[0];
    assign bus.gnt         = ~(wr_data_hit & tx_full);
    assign acc             = bus.req & bus.gnt;
    assign reg_wr          = acc & bus.we;
    assign be_mask         = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};

    assign tx_push = acc & wr_data_hit;
    assign rx_pop  = acc & ~bus.we & (word == REG_DATA) & ~rx_empty;

    assign div_eff = (div_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_q;

    assign tx_busy  = (tx_state != TX_IDLE);
    assign tx_bound = (tx_cnt == tx_per - 1'b1);
    assign tx_pop   = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bound));

    assign rx_s         = rx_sync[1];
    assign rx_fall      = rx_prev & ~rx_s;
    assign rx_bound     = (rx_cnt == rx_per - 1'b1);
    assign rx_mid       = (rx_cnt == (rx_per >> 1) - 1'b1);
    assign rx_push      = (rx_state == RX_STOP) & rx_bound & rx_s;
    assign rx_frame_evt = (rx_state == RX_STOP) & rx_bound & ~rx_s;
    assign rx_ovf_evt   = rx_push & rx_full & ~rx_pop;

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign ser_tx_o   = ser_tx_q;
    assign irq_o      = (irq_en_q[IRQ_RX_NOT_EMPTY] & ~rx_empty)
                      | (irq_en_q[IRQ_TX_EMPTY] & tx_empty & ~tx_busy);

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (tx_push),
        .push_dat (bus.wdata[7:0]),
        .pop_vld  (tx_pop),
        .pop_dat  (tx_dout),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (rx_push),
        .push_dat (rx_sh),
        .pop_vld  (rx_pop),
        .pop_dat  (rx_dout),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // Read data selection for the addressed register
    always_comb begin
        rd_mux = '0;
        case (word)
            REG_DATA:   rd_mux = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_dout};
            REG_STATUS: begin
                rd_mux[ST_TX_FULL]    = tx_full;
                rd_mux[ST_TX_EMPTY]   = tx_empty;
                rd_mux[ST_RX_EMPTY]   = rx_empty;
                rd_mux[ST_RX_FULL]    = rx_full;
                rd_mux[ST_RX_OVERRUN] = rx_overrun_q;
                rd_mux[ST_TX_BUSY]    = tx_busy;
                rd_mux[ST_FRAME_ERR]  = frame_err_q;
            end
            REG_DIV:    rd_mux[DIV_WIDTH-1:0] = div_q;
            default:    rd_mux[1:0] = irq_en_q;
        endcase
    end

    // Response channel: one response per grant, data held until the next one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= acc;
            if (acc) rdata_q <= bus.we ? 32'h0 : rd_mux;
        end
    end

    // Register writes and sticky flags; a new error event wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q        <= DIV_RST;
            irq_en_q     <= '0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (reg_wr && word == REG_DIV)
                div_q <= (div_q & ~be_mask[DIV_WIDTH-1:0]) | (bus.wdata[DIV_WIDTH-1:0] & be_mask[DIV_WIDTH-1:0]);
            if (reg_wr && word == REG_IRQ_EN && bus.be[0])
                irq_en_q <= bus.wdata[1:0];
            if (rx_ovf_evt)
                rx_overrun_q <= 1'b1;
            else if (reg_wr && word == REG_STATUS && bus.be[0] && bus.wdata[ST_RX_OVERRUN])
                rx_overrun_q <= 1'b0;
            if (rx_frame_evt)
                frame_err_q <= 1'b1;
            else if (reg_wr && word == REG_STATUS && bus.be[0] && bus.wdata[ST_FRAME_ERR])
                frame_err_q <= 1'b0;
        end
    end

    // TX engine: bit period latched at each bit boundary; STOP chains straight into START
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_per   <= DIV_RST;
            tx_bit   <= '0;
            tx_sh    <= '0;
            ser_tx_q <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    ser_tx_q <= 1'b1;
                    tx_cnt   <= '0;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_per   <= div_eff;
                        tx_sh    <= tx_dout;
                        ser_tx_q <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bound) begin
                        tx_cnt   <= '0;
                        tx_per   <= div_eff;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                        ser_tx_q <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bound) begin
                        tx_cnt <= '0;
                        tx_per <= div_eff;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            ser_tx_q <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            ser_tx_q <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bound) begin
                        tx_cnt <= '0;
                        tx_per <= div_eff;
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_sh    <= tx_dout;
                            ser_tx_q <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                            ser_tx_q <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    ser_tx_q <= 1'b1;
                end
            endcase
        end
    end

    // RX line synchroniser and edge history, reset to the idle-high level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], ser_rx_i};
            rx_prev <= rx_s;
        end
    end

    // RX engine: mid-start qualification, then one sample per bit period
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_per   <= DIV_RST;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_per   <= div_eff;
                    end
                end
                RX_START: begin
                    if (rx_mid) begin
                        rx_cnt <= '0;
                        if (!rx_s) begin
                            rx_state <= RX_DATA;
                            rx_per   <= div_eff;
                            rx_bit   <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bound) begin
                        rx_cnt <= '0;
                        rx_per <= div_eff;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bound) begin
                        rx_cnt   <= '0;
                        rx_per   <= div_eff;
                        rx_state <= rx_s ? RX_IDLE : RX_BREAK;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    rx_cnt <= '0;
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_obi_periph.sv
module tb_uart_obi_periph;
    localparam int DIVR = 25_000_000 / 115200;
    localparam int TXD  = 8;
    localparam int RXD  = 8;
    localparam int D    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_tx, ser_rx, irq;
    logic loopback = 1'b0;
    logic rx_drv = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [7:0] mon_q[$];
    int   mon_stop_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ser_rx = loopback ? ser_tx : rx_drv;

    uart_obi_periph_if bus();

    uart_obi_periph #(
        .CLK_FREQ (25_000_000),
        .BAUDRATE (115200),
        .DIV_WIDTH(16),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .ser_tx_o(ser_tx),
        .ser_rx_i(ser_rx),
        .irq_o   (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction; returns read data, cycles spent waiting for grant, grant edge number
    task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int waited, output int gcyc);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = 4'hF;
        waited = 0;
        #1;
        while (bus.gnt !== 1'b1 && waited < 2000) begin
            @(negedge clk); #1; waited++;
        end
        if (waited >= 2000) check("gnt_timeout", bus.gnt, 1);
        @(posedge clk); #1;
        gcyc = cyc;
        bus.req = 1'b0;
        check("rvalid", bus.rvalid, 1);
        rd = bus.rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r; int w; int g;
        xfer(1'b1, a, d, r, w, g);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r; int w; int g;
        xfer(1'b0, a, 32'h0, r, w, g);
        check(tag, r, exp);
    endtask

    // Bit-bang one frame onto ser_rx_i at D cycles per bit
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx_drv = f[i];
            repeat (D - 1) @(negedge clk);
        end
    endtask

    // Serial line decoder: samples mid-bit at D cycles per bit
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && ser_tx === 1'b0) begin
                repeat (D + D / 2) @(posedge clk);
                #1; b[0] = ser_tx;
                for (int k = 1; k < 8; k++) begin
                    repeat (D) @(posedge clk);
                    #1; b[k] = ser_tx;
                end
                repeat (D) @(posedge clk);
                #1;
                if (ser_tx !== 1'b1) mon_stop_bad++;
                mon_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] r;
        int          w, g, t;
        logic [9:0]  frame;
        logic [7:0]  b;
        logic [7:0]  sent[$];
        logic [7:0]  rx_model[$];
        int          wt[TXD + 2];
        int          gc[TXD + 2];
        logic [31:0] exp_st;

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.be = 4'h0; bus.wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_gnt", bus.gnt, 1);
        rst_n = 1'b1;
        rd_chk("rst_status", 4'h4, 32'h06);
        rd_chk("rst_div", 4'h8, DIVR);
        rd_chk("rst_irq_en", 4'hC, 32'h0);
        rd_chk("rst_data_empty", 4'h0, 32'hFFFF_FFFF);

        // Divider register
        wr(4'h8, 32'h1);
        rd_chk("div_rd1", 4'h8, 32'h1);
        wr(4'h8, D);
        rd_chk("div_rd4", 4'h8, D);

        // Single byte 0x55: exact line waveform, D cycles per bit
        xfer(1'b1, 4'h0, 32'h55, r, w, g);
        check("tx55_pre", ser_tx, 1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10 * D; i++) begin
            @(posedge clk); #1;
            check($sformatf("tx55_c%0d", i), ser_tx, frame[i / D]);
        end
        @(posedge clk); #1;
        check("tx55_idle", ser_tx, 1);
        rd_chk("tx55_status", 4'h4, 32'h06);

        // Back-to-back writes overrunning the TX FIFO
        mon_q.delete();
        for (int i = 0; i < TXD + 2; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            xfer(1'b1, 4'h0, {24'h0, b}, r, w, g);
            wt[i] = w;
            gc[i] = g;
        end
        for (int i = 0; i <= TXD; i++) check($sformatf("gnt_wait%0d", i), wt[i], 0);
        check("gnt_drop", (wt[TXD + 1] > 0), 1);
        check("gnt_reassert", gc[TXD + 1] - gc[0], 10 * D + 2);
        t = 0;
        while (mon_q.size() < TXD + 2 && t < 2000) begin
            @(posedge clk); t++;
        end
        check("mon_count", mon_q.size(), TXD + 2);
        for (int i = 0; i < TXD + 2 && i < mon_q.size(); i++)
            check($sformatf("tx_byte%0d", i), mon_q[i], sent[i]);
        check("mon_stop_bits", mon_stop_bad, 0);
        repeat (2 * D) @(posedge clk);
        rd_chk("b2b_status", 4'h4, 32'h06);

        // Loopback single byte, RX-not-empty interrupt
        @(negedge clk); loopback = 1'b1;
        wr(4'hC, 32'h1);
        wr(4'h0, 32'hA3);
        repeat (10 * D + 10) @(posedge clk);
        #1;
        check("lb_irq", irq, 1);
        rd_chk("lb_status", 4'h4, 32'h02);
        rd_chk("lb_data", 4'h0, 32'hA3);
        check("lb_irq_clr", irq, 0);
        rd_chk("lb_data_empty", 4'h0, 32'hFFFF_FFFF);
        wr(4'hC, 32'h2);
        check("irq_tx_empty", irq, 1);
        wr(4'hC, 32'h0);
        check("irq_off", irq, 0);

        // RX overrun: RXD+1 frames with no reads
        for (int i = 0; i < RXD + 1; i++) begin
            b = 8'($urandom);
            if (rx_model.size() < RXD) rx_model.push_back(b);
            wr(4'h0, {24'h0, b});
        end
        repeat ((RXD + 1) * 10 * D + 10 * D) @(posedge clk);
        exp_st = 32'h02 | ((rx_model.size() == RXD) ? 32'h08 : 32'h0) | 32'h10;
        rd_chk("ovr_status", 4'h4, exp_st);
        while (rx_model.size() > 0) begin
            b = rx_model.pop_front();
            rd_chk("ovr_data", 4'h0, {24'h0, b});
        end
        rd_chk("ovr_drained", 4'h0, 32'hFFFF_FFFF);
        wr(4'h4, 32'h10);
        rd_chk("ovr_cleared", 4'h4, 32'h06);

        // Framing error, glitch rejection, directly driven good frame
        @(negedge clk); loopback = 1'b0; rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        drive_frame(8'h5A, 1'b0);
        repeat (2 * D) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("ferr_status", 4'h4, 32'h46);
        rd_chk("ferr_no_push", 4'h0, 32'hFFFF_FFFF);
        wr(4'h4, 32'h40);
        rd_chk("ferr_cleared", 4'h4, 32'h06);
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk("glitch_status", 4'h4, 32'h06);
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        repeat (10) @(negedge clk);
        rd_chk("rx_direct", 4'h0, {24'h0, b});

        // Reset in the middle of a TX frame
        wr(4'h8, 32'h8);
        wr(4'h0, 32'h00);
        repeat (20) @(posedge clk);
        #1;
        check("mid_tx_low", ser_tx, 0);
        rd_chk("mid_status", 4'h4, 32'h26);
        rst_n = 1'b0;
        #1;
        check("arst_ser_tx", ser_tx, 1);
        check("arst_rvalid", bus.rvalid, 0);
        check("arst_rdata", bus.rdata, 0);
        check("arst_irq", irq, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_div", 4'h8, DIVR);
        rd_chk("post_rst_data", 4'h0, 32'hFFFF_FFFF);
        rd_chk("post_rst_status", 4'h4, 32'h06);
        check("post_rst_ser_tx", ser_tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
